// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked WIDTH-generic ALU with a registered result/flag stage
// Define ALU_MUL_EN to build op 1010 as a WIDTH-cycle shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  localparam logic ST_IDLE = 1'b0;

  logic             state;
  logic             accept;
  logic             drain;
  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  logic             load;
  logic [WIDTH-1:0] load_res;
  logic             load_c;
  logic             load_v;

  assign in_ready = (state == ST_IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    is_sub   = (ALUControl == OP_SUB);
    is_arith = (ALUControl == OP_ADD) | is_sub;
    b_eff    = is_sub ? ~B : B;
    sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt    = B[SHW-1:0];
    alu_res  = '0;
    case (ALUControl)
      OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
      OP_AND:         alu_res = A & B;
      OP_OR:          alu_res = A | B;
      OP_XOR:         alu_res = A ^ B;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, A < B};
      OP_SLL:         alu_res = A << shamt;
      OP_SRL:         alu_res = A >> shamt;
      OP_SRA:         alu_res = $signed(A) >>> shamt;
      // mul never loads from here when the multiplier is built
      OP_MUL:         alu_res = '0;
      default:        alu_res = '0;
    endcase
    alu_c = is_arith & sum[WIDTH];
    alu_v = is_arith & (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
  end

`ifdef ALU_MUL_EN
  localparam logic ST_MUL = 1'b1;

  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             mul_start;
  logic             mul_done;

  assign mul_start = accept & (ALUControl == OP_MUL);
  assign mul_done  = (state == ST_MUL) & (count == SHW'(WIDTH - 1));
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  // One multiplier bit per cycle, LSB first; multiplicand shifts up in step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (mul_start) begin
      state  <= ST_MUL;
      count  <= '0;
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
    end else if (state == ST_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (mul_done) state <= ST_IDLE;
    end
  end

  assign load     = (accept & ~mul_start) | mul_done;
  assign load_res = mul_done ? acc_next : alu_res;
  assign load_c   = ~mul_done & alu_c;
  assign load_v   = ~mul_done & alu_v;
`else
  assign state    = ST_IDLE;
  assign load     = accept;
  assign load_res = alu_res;
  assign load_c   = alu_c;
  assign load_v   = alu_v;
`endif

  // A load always wins over a drain: accept-and-drain keeps out_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Carry     <= 1'b0;
      OverFlow  <= 1'b0;
      Zero      <= 1'b0;
      Negative  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      Result    <= load_res;
      Carry     <= load_c;
      OverFlow  <= load_v;
      Zero      <= (load_res == '0);
      Negative  <= load_res[WIDTH-1];
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized self-checking bench for alu_pipe against a behavioural model
// Expectations for op 1010 follow ALU_MUL_EN.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALUControl = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Result;
  logic        Carry, OverFlow, Zero, Negative;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Carry(Carry), .OverFlow(OverFlow), .Zero(Zero), .Negative(Negative)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Returns {carry, overflow, result} from plain 64-bit arithmetic.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sr;
    logic [63:0] w;
    logic [31:0] r;
    logic        c, v;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        w = {32'b0, a} + {32'b0, b};
        r = w[31:0]; c = w[32];
        sr = sa + sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        sr = sa - sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: begin sr = sa >>> b[4:0]; r = sr[31:0]; end
`ifdef ALU_MUL_EN
      4'd10: begin w = {32'b0, a} * {32'b0, b}; r = w[31:0]; end
`endif
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = 32'h0;
      1: r = 32'hFFFFFFFF;
      2: r = 32'h80000000;
      3: r = 32'h7FFFFFFF;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] rnd_op();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 4'd10) op = 4'd0;
    return op;
  endfunction

  task automatic check_res(input string tag, input logic [33:0] e);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, Result, e[31:0]);
    check({tag, "_carry"}, Carry, e[33]);
    check({tag, "_ovf"}, OverFlow, e[32]);
    check({tag, "_zero"}, Zero, (e[31:0] == 32'd0));
    check({tag, "_neg"}, Negative, e[31]);
  endtask

  // Presents one op, returns #1 after the accepting edge with inputs scrambled.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; ALUControl = op; A = a; B = b;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] e;
    e = model(op, a, b);
    issue(op, a, b);
`ifdef ALU_MUL_EN
    if (op == 4'd10) begin
      for (int i = 0; i < 31; i++) begin
        check({tag, "_busy_ready"}, in_ready, 0);
        check({tag, "_busy_valid"}, out_valid, 0);
        @(posedge clk); #1;
      end
      check({tag, "_last_busy_valid"}, out_valid, 0);
      @(posedge clk); #1;
    end
`endif
    check_res(tag, e);
  endtask

  initial begin
    logic [33:0] exp_q[$];
    logic [33:0] e9, eres, mres;
    logic        mvalid, pend, acc, exp_ready;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_flags", {Carry, OverFlow, Zero, Negative}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid_after", out_valid, 0);

    run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1);
    run_op("sub_eq", 4'd1, 32'd5, 32'd5);
    run_op("sltu", 4'd6, 32'd1, 32'hFFFFFFFF);
    run_op("slt", 4'd5, 32'd1, 32'hFFFFFFFF);
    run_op("sra", 4'd9, 32'h80000000, 32'h24);
    run_op("sll", 4'd7, 32'h1, 32'd31);
    run_op("shift0", 4'd8, 32'hDEADBEEF, 32'h20);
    run_op("mul", 4'd10, 32'h00010003, 32'd5);
    run_op("mul_rnd", 4'd10, $urandom, $urandom);
    for (int op = 11; op < 16; op++) run_op("illegal", 4'(op), $urandom, $urandom);
    for (int i = 0; i < 60; i++) run_op("rnd_op", rnd_op(), rnd_val(), rnd_val());

    // Back-to-back adds, then a 3-cycle consumer stall.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; ALUControl = 4'd0;
    for (int k = 0; k < 8; k++) begin
      A = $urandom; B = $urandom;
      exp_q.push_back(model(4'd0, A, B));
      #1;
      check("b2b_ready", in_ready, 1);
      @(posedge clk); #1;
      check_res("b2b", exp_q.pop_front());
    end
    A = $urandom; B = $urandom; ALUControl = 4'd1;
    e9 = model(4'd1, A, B);
    eres = model(4'd0, 32'd0, 32'd0);
    out_ready = 1'b0;
    #1;
    check("stall_ready0", in_ready, 0);
    mres = {Carry, OverFlow, Result};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_hold", {Carry, OverFlow, Result}, mres[31:0]);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", in_ready, 1);
    @(posedge clk); #1;
    check_res("release", e9);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drained", out_valid, 0);

    // Random handshake traffic against a one-entry output model.
    mvalid = 1'b0; pend = 1'b0;
    for (int it = 0; it < 300; it++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 2) != 0);
        ALUControl = rnd_op(); A = rnd_val(); B = rnd_val();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = !mvalid || out_ready;
      check("rnd_in_ready", in_ready, exp_ready);
      acc = in_valid && exp_ready;
      if (acc) eres = model(ALUControl, A, B);
      @(posedge clk); #1;
      if (acc) begin
        mvalid = 1'b1; mres = eres;
      end else if (mvalid && out_ready) begin
        mvalid = 1'b0;
      end
      pend = in_valid && !acc;
      check("rnd_out_valid", out_valid, mvalid);
      if (mvalid) check_res("rnd", mres);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    issue(4'd10, 32'h00010003, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    check("midmul_busy", in_ready, 0);
`else
    out_ready = 1'b0;
    issue(4'd3, 32'h12340000, 32'h00005678);
    check("stalled_valid", out_valid, 1);
`endif
    rst = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_result", Result, 0);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_no_stale", out_valid, 0);
    run_op("post_rst_add", 4'd0, 32'd2, 32'd3);
    check("post_rst_five", Result, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
